// File: rtl/leg_uart_pkg.sv
// Shared types and width helpers for the LEG UART.
// State names are common to the TX and RX sequencers.
package leg_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Bits needed for a counter that holds 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/leg_uart_fifo.sv
// First-word-fall-through synchronous FIFO with one extra pointer bit for full/empty.
// o_data shows the head entry whenever o_empty is low.
module leg_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_push,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_pop,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign o_data   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/leg_uart.sv
// LEG UART transceiver: FIFO-buffered TX/RX with framing and overrun reporting.
// Define LEG_UART_PARITY_EN to add one even-parity bit per frame on TX and RX.
module leg_uart
    import leg_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    input  logic                 rx,
    output logic                 tx,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_tx_busy
);
    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_width(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty, tx_full, tx_pop;
    logic                 rx_full, rx_empty, rx_push;

    leg_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (i_tx_data),
        .i_push  (i_tx_valid),
        .o_full  (tx_full),
        .o_data  (tx_head),
        .i_pop   (tx_pop),
        .o_empty (tx_empty)
    );

    // ---------------- TX ----------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [BAUD_W-1:0]    tx_baud_q, tx_baud_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_bit_end;
`ifdef LEG_UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_bit_end = (tx_baud_q == BAUD_LAST);
    assign tx         = tx_line_q;
    assign o_tx_ready = !tx_full;
    assign o_tx_busy  = (tx_state_q != IDLE) || !tx_empty;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_bit_end ? '0 : tx_baud_q + BAUD_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
`ifdef LEG_UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            IDLE: begin
                tx_baud_d = '0;
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
`ifdef LEG_UART_PARITY_EN
                    tx_par_d   = ^tx_head;
`endif
                    tx_state_d = START;
                    tx_line_d  = 1'b0;
                end
            end
            START: begin
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_state_d = DATA;
                    tx_line_d  = tx_shift_q[0];
                end
            end
            DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BIT_LAST) begin
`ifdef LEG_UART_PARITY_EN
                        tx_state_d = PARITY;
                        tx_line_d  = tx_par_q;
`else
                        tx_state_d = STOP;
                        tx_line_d  = 1'b1;
`endif
                    end else begin
                        tx_bit_d  = tx_bit_q + BIT_W'(1);
                        tx_line_d = tx_shift_q[1];
                    end
                end
            end
`ifdef LEG_UART_PARITY_EN
            PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = STOP;
                    tx_line_d  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tx_bit_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
`ifdef LEG_UART_PARITY_EN
                        tx_par_d   = ^tx_head;
`endif
                        tx_state_d = START;
                        tx_line_d  = 1'b0;
                    end else begin
                        tx_state_d = IDLE;
                        tx_line_d  = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state_q <= IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
`ifdef LEG_UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
`ifdef LEG_UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // ---------------- RX ----------------
    uart_state_e          rx_state_q, rx_state_d;
    logic [BAUD_W-1:0]    rx_baud_q, rx_baud_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_stop_ok;
`ifdef LEG_UART_PARITY_EN
    logic                 rx_par_err_q, rx_par_err_d;
    assign rx_stop_ok = rx_sync_q && !rx_par_err_q;
`else
    assign rx_stop_ok = rx_sync_q;
`endif

    leg_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_data  (rx_shift_q),
        .i_push  (rx_push),
        .o_full  (rx_full),
        .o_data  (o_rx_data),
        .i_pop   (i_rx_ready),
        .o_empty (rx_empty)
    );

    assign o_rx_valid  = !rx_empty;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q + BAUD_W'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef LEG_UART_PARITY_EN
        rx_par_err_d = rx_par_err_q;
`endif
        case (rx_state_q)
            IDLE: begin
                // The edge-detect cycle is position 0 of the start bit.
                rx_baud_d = BAUD_W'(1);
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = START;
                end
            end
            START: begin
                if (rx_baud_q == BAUD_HALF) begin
                    rx_baud_d = '0;
                    rx_bit_d  = '0;
                    rx_state_d = rx_sync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
`ifdef LEG_UART_PARITY_EN
                        rx_state_d = PARITY;
`else
                        rx_state_d = STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef LEG_UART_PARITY_EN
            PARITY: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d    = '0;
                    rx_par_err_d = ^{rx_shift_q, rx_sync_q};
                    rx_state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // A low line after an error needs a fresh falling edge in IDLE,
                // which only occurs once rx has returned high.
                if (rx_baud_q == BAUD_LAST) begin
                    rx_state_d = IDLE;
                    if (rx_stop_ok) begin
                        rx_push   = 1'b1;
                        overrun_d = rx_full && !i_rx_ready;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= IDLE;
            rx_baud_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef LEG_UART_PARITY_EN
            rx_par_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef LEG_UART_PARITY_EN
            rx_par_err_q <= rx_par_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_leg_uart.sv
// Self-checking bench for leg_uart (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4).
// Honours LEG_UART_PARITY_EN for the frame model and the parity-error case.
module tb_leg_uart;
    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int FD  = 4;
`ifdef LEG_UART_PARITY_EN
    localparam int NBITS   = DB + 3;
    localparam int PAR_IDX = DB + 1;
`else
    localparam int NBITS   = DB + 2;
    localparam int PAR_IDX = -1;
`endif

    logic          i_clk, i_rst;
    logic [DB-1:0] i_tx_data, o_rx_data;
    logic          i_tx_valid, o_tx_ready, o_rx_valid, i_rx_ready;
    logic          rx, tx, o_frame_err, o_overrun, o_tx_busy;

    leg_uart #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tx_data   (i_tx_data),
        .i_tx_valid  (i_tx_valid),
        .o_tx_ready  (o_tx_ready),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .i_rx_ready  (i_rx_ready),
        .rx          (rx),
        .tx          (tx),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_tx_busy   (o_tx_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ovr_cnt  = 0;

    always @(negedge i_clk) begin
        if (o_frame_err === 1'b1) fe_cnt++;
        if (o_overrun === 1'b1) ovr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of frame bit k: start, data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= DB) return b[k-1];
        if (k == PAR_IDX) return ($countones(b) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic push_tx(input logic [7:0] b);
        int guard;
        @(negedge i_clk);
        i_tx_data  = b;
        i_tx_valid = 1'b1;
        guard = 0;
        while (!o_tx_ready && guard < 2000) begin
            @(negedge i_clk);
            guard++;
        end
        @(posedge i_clk);
        #1 i_tx_valid = 1'b0;
    endtask

    task automatic tx_expect_frame(input logic [7:0] b, input bit wait_start, input string tag);
        logic [3:0] s;
        logic [3:0] e4;
        logic       eb;
        int         guard;
        if (wait_start) begin
            guard = 0;
            do begin
                @(negedge i_clk);
                guard++;
            end while (tx !== 1'b0 && guard < 2000);
        end else begin
            @(negedge i_clk);
        end
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k != 0 || c != 0) @(negedge i_clk);
                s[c] = tx;
            end
            eb = frame_bit(b, k);
            e4 = {4{eb}};
            check($sformatf("%s_bit%0d", tag, k), 16'(s), 16'(e4));
        end
        $display("tx frame %s byte=%02h checked", tag, b);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit good_stop, input bit flip_par);
        logic eb;
        for (int k = 0; k < NBITS; k++) begin
            eb = frame_bit(b, k);
            if (k == NBITS - 1) eb = good_stop;
            if (flip_par && k == PAR_IDX) eb = ~eb;
            @(negedge i_clk);
            rx = eb;
            repeat (CPB - 1) @(negedge i_clk);
        end
        @(negedge i_clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge i_clk);
        $display("rx frame sent byte=%02h stop=%0b flip_par=%0b", b, good_stop, flip_par);
    endtask

    task automatic rx_pop_expect(input logic [7:0] exp, input string tag);
        @(negedge i_clk);
        check({tag, "_valid"}, 16'(o_rx_valid), 16'h1);
        check({tag, "_data"}, 16'(o_rx_data), 16'(exp));
        i_rx_ready = 1'b1;
        @(posedge i_clk);
        #1 i_rx_ready = 1'b0;
    endtask

    logic [7:0] rxq[$];
    logic [7:0] vals[5];
    logic [7:0] b;
    int         fe0, ovr0, exp_ovr, lows, guard;

    initial begin
        i_rst = 1'b1; rx = 1'b1; i_tx_valid = 1'b0; i_tx_data = '0; i_rx_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_tx", 16'(tx), 16'h1);
        check("rst_tx_ready", 16'(o_tx_ready), 16'h1);
        check("rst_rx_valid", 16'(o_rx_valid), 16'h0);
        check("rst_frame_err", 16'(o_frame_err), 16'h0);
        check("rst_overrun", 16'(o_overrun), 16'h0);
        check("rst_tx_busy", 16'(o_tx_busy), 16'h0);

        // Single byte, then busy must clear after the stop bit.
        push_tx(8'hA5);
        @(negedge i_clk);
        check("t1_busy_after_push", 16'(o_tx_busy), 16'h1);
        tx_expect_frame(8'hA5, 1'b1, "t1");
        repeat (2) @(negedge i_clk);
        check("t1_busy_end", 16'(o_tx_busy), 16'h0);
        check("t1_tx_idle", 16'(tx), 16'h1);

        // Five back-to-back bytes: FIFO fills, frames run with no idle gap.
        fork
            begin
                for (int i = 1; i <= 5; i++) push_tx(8'(i));
                @(negedge i_clk);
                check("t2_ready_full", 16'(o_tx_ready), 16'h0);
            end
            begin
                tx_expect_frame(8'h01, 1'b1, "t2f1");
                for (int i = 2; i <= 5; i++) tx_expect_frame(8'(i), 1'b0, $sformatf("t2f%0d", i));
            end
        join
        @(negedge i_clk);
        check("t2_busy_end", 16'(o_tx_busy), 16'h0);

        // Random TX bytes.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            push_tx(b);
            tx_expect_frame(b, 1'b1, $sformatf("trnd%0d", i));
        end
`ifdef LEG_UART_PARITY_EN
        push_tx(8'h07);
        tx_expect_frame(8'h07, 1'b1, "tpar07");
`endif

        // RX word held while the core is not ready.
        send_rx(8'h3C, 1'b1, 1'b0);
        @(negedge i_clk);
        check("t3_valid", 16'(o_rx_valid), 16'h1);
        check("t3_data", 16'(o_rx_data), 16'h3C);
        repeat (5) @(negedge i_clk);
        check("t3_data_stable", 16'(o_rx_data), 16'h3C);
        rx_pop_expect(8'h3C, "t3_pop");
        @(negedge i_clk);
        check("t3_empty", 16'(o_rx_valid), 16'h0);

        // Overrun: five words into a four-entry FIFO.
        ovr0 = ovr_cnt;
        for (int i = 0; i < 5; i++) begin
            vals[i] = 8'($urandom);
            send_rx(vals[i], 1'b1, 1'b0);
        end
        check("t4_overrun_once", 16'(ovr_cnt - ovr0), 16'h1);
        for (int i = 0; i < 4; i++) rx_pop_expect(vals[i], $sformatf("t4_pop%0d", i));
        @(negedge i_clk);
        check("t4_empty", 16'(o_rx_valid), 16'h0);

        // Framing error, then a glitch, then a clean frame.
        fe0 = fe_cnt;
        send_rx(8'h55, 1'b0, 1'b0);
        check("t5_frame_err_once", 16'(fe_cnt - fe0), 16'h1);
        check("t5_no_push", 16'(o_rx_valid), 16'h0);
        @(negedge i_clk); rx = 1'b0;
        @(negedge i_clk); rx = 1'b1;
        repeat (3 * CPB) @(negedge i_clk);
        check("t5_glitch_no_err", 16'(fe_cnt - fe0), 16'h1);
        check("t5_glitch_no_push", 16'(o_rx_valid), 16'h0);
        send_rx(8'h96, 1'b1, 1'b0);
        rx_pop_expect(8'h96, "t5_after_glitch");
`ifdef LEG_UART_PARITY_EN
        fe0 = fe_cnt;
        send_rx(8'h07, 1'b1, 1'b1);
        check("tpar_err", 16'(fe_cnt - fe0), 16'h1);
        check("tpar_no_push", 16'(o_rx_valid), 16'h0);
`endif

        // Random RX traffic against a queue model, with occasional draining.
        ovr0 = ovr_cnt;
        exp_ovr = 0;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1, 1'b0);
            if (rxq.size() < FD) rxq.push_back(b);
            else exp_ovr++;
            if ($urandom_range(0, 2) == 0) begin
                while (rxq.size() > 0) rx_pop_expect(rxq.pop_front(), $sformatf("rrnd%0d", i));
            end
        end
        while (rxq.size() > 0) rx_pop_expect(rxq.pop_front(), "rrnd_drain");
        check("rrnd_overruns", 16'(ovr_cnt - ovr0), 16'(exp_ovr));

        // Reset in the middle of a TX data bit with RX data pending.
        send_rx(8'h42, 1'b1, 1'b0);
        push_tx(8'hC3);
        push_tx(8'h11);
        guard = 0;
        do begin
            @(negedge i_clk);
            guard++;
        end while (tx !== 1'b0 && guard < 2000);
        check("t6_tx_started", 16'(tx), 16'h0);
        repeat (3 * CPB + 1) @(negedge i_clk);
        check("t6_pre_rx_valid", 16'(o_rx_valid), 16'h1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("t6_tx_high", 16'(tx), 16'h1);
        check("t6_tx_ready", 16'(o_tx_ready), 16'h1);
        check("t6_rx_valid", 16'(o_rx_valid), 16'h0);
        check("t6_tx_busy", 16'(o_tx_busy), 16'h0);
        lows = 0;
        repeat (4 * NBITS * CPB) begin
            @(negedge i_clk);
            if (tx !== 1'b1) lows++;
        end
        check("t6_tx_abandoned", 16'(lows), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
